output_bram_address_generator: RTL and testbench
================================================

# output_bram_address_generator

Sequential successor to the combinational output-BRAM address decoder. It walks a whole output tile of channels `[start..end]` × rows × cols and emits one BRAM write target per beat over a valid/ready handshake: bank select, in-bank address and the feature coordinates. It sits between the PE-array output stage and the `OUTPUT_BRAM_NUM` output BRAM banks. Addresses are built incrementally, with no per-beat multipliers, and two traversal orders are supported.

## Interface
- `OUTPUT_CHANNEL_WIDTH`, default 8: channel index width.
- `OUTPUT_ROW_WIDTH`, default 6: row index width.
- `OUTPUT_COL_WIDTH`, default 6: col index width.
- `OUTPUT_BRAM_NUM`, default 4: number of banks; must be a power of 2 and ≥2.
- `OUTPUT_BRAM_DEPTH`, default 1152: words per bank.
- `OUTPUT_BRAM_ADDRESS_WIDTH`, default `$clog2(OUTPUT_BRAM_DEPTH)`: in-bank address width.
- `BANK_SEL_WIDTH`, default `$clog2(OUTPUT_BRAM_NUM)`: bank select width.

Ports (name, direction, width, meaning):
- `i_clk` in 1: single clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: start a tile; sampled only in IDLE.
- `i_abort` in 1: synchronous abort; return to IDLE, no done.
- `i_mode` in 1: traversal order, latched at start. 0 = planar (col innermost, channel outermost). 1 = pixel-major (channel innermost).
- `i_output_feature_row` in ROW: rows per channel (R).
- `i_output_feature_col` in COL: cols per row (C).
- `i_output_start_index_channel` in CH: first channel (S).
- `i_output_end_index_channel` in CH: last channel (E), inclusive.
- `i_ready` in 1: consumer accepts the current beat.
- `o_valid` out 1: beat valid.
- `o_bank_sel` out BANK_SEL: target bank.
- `o_output_feature_address` out ADDR: in-bank address.
- `o_output_feature_channel_data_point` out CH: channel of the beat.
- `o_output_feature_row_data_point` out ROW: row of the beat.
- `o_output_feature_col_data_point` out COL: col of the beat.
- `o_last` out 1: final beat of the tile.
- `o_busy` out 1: high in RUN.
- `o_done` out 1: one-cycle completion pulse.
- `o_error` out 1: one-cycle pulse when a start is rejected.

## Operation
- **Mapping.** With rel = ch − S:
  - bank = rel mod NUM
  - group = rel / NUM
  - address = group·R·C + row·C + col
- **States.** IDLE, RUN, DONE.
  - IDLE + `i_start` + legal config → RUN. Config and mode are latched on this edge.
  - IDLE + `i_start` + illegal config → `o_error` pulse, stay in IDLE.
  - RUN + handshake on the beat with `o_last` → DONE.
  - DONE → IDLE after one cycle.
- **Illegal config** (any of):
  - E < S
  - R = 0 or C = 0
  - (⌊(E−S)/NUM⌋+1)·R·C > OUTPUT_BRAM_DEPTH

  Evaluate this at ADDR+CH+ROW+COL bits so it cannot overflow.
- **Internal registers.**
  - `base` accumulates R·C per group. R·C is computed once at start.
  - `pix` = row·C+col, maintained by +1 steps.
  - address = base + pix, truncated to ADDR bits; legal configs never truncate.
- **Mode 0, per handshake.**
  - col++, pix++.
  - col wrap → col=0, row++.
  - row wrap → row=0, pix=0, channel++, bank++.
  - bank wrap to 0 → base += R·C.
- **Mode 1, per handshake.**
  - channel++, bank++.
  - bank wrap → base += R·C.
  - channel passes E → channel=S, bank=0, base=0, then advance col/row/pix as in mode 0 (no channel step).
- **Last beat.** `o_last` = (ch=E && row=R−1 && col=C−1).
- **Abort.** `i_abort` in RUN or DONE → IDLE next cycle; `o_valid`, `o_busy` and `o_done` go low and no done pulse is issued. In IDLE, `i_abort` has priority over `i_start`.
- **Reset.** `i_rst` has priority over everything. All outputs are 0 and state is IDLE.

## Timing
- **Start latency.** `i_start` accepted at cycle t → `o_busy`=1 and `o_valid`=1 with the first beat (ch=S, row=0, col=0, bank 0, address 0) at t+1.
- **Throughput.** One beat per cycle while `i_ready`=1.
- **Backpressure.** While `o_valid`=1 and `i_ready`=0, every beat output holds stable. `o_valid` never drops mid-tile except on abort or reset.
- **Completion.** Final handshake at cycle t → at t+1: `o_valid`=0, `o_busy`=0, `o_done`=1. At t+2: IDLE, and a new start is accepted.
- **Ignored starts.** `i_start` in RUN or DONE is ignored.
- **Error pulse.** `o_error` is high for exactly the cycle after the rejected start.
- **Registered outputs.** All outputs come from registers; there is no combinational path from `i_ready` to any output except through the state registers.

## Structure
- **Shared package `output_bram_pkg`** holds:
  - the state enum `out_gen_state_t` {IDLE, RUN, DONE};
  - mode localparams `MODE_PLANAR`=0 and `MODE_PIXEL`=1;
  - the default width and depth constants shared with the BRAM wrapper.
- **One sub-module, `output_tile_config_checker`.** Combinational legality check and R·C product; it outputs `cfg_ok` and `plane_size`.

## Test plan
- **Planar walk.** NUM=4, R=2, C=3, S=0, E=7, mode 0, `i_ready`=1 → 48 beats. Beat for ch5, row1, col2 has bank 1, address 11. The final beat (ch7, r1, c2) has bank 3, address 11 and `o_last`=1. `o_done` comes one cycle later.
- **Pixel-major walk.** Same config, mode 1 → beats 0–3 are ch0–3, banks 0–3, address 0. Beats 4–7 are ch4–7, banks 0–3, address 6. Beat 8 is ch0, row0, col1, bank 0, address 1.
- **Backpressure.** Toggle `i_ready` pseudo-randomly → outputs stay stable while stalled. The beat sequence is identical to the unstalled run, with no drops or duplicates.
- **Config rejection.** (a) S=10, E=4 → `o_error` pulse, `o_valid` stays 0. (b) R=C=24, S=0, E=15 (4·576=2304 > 1152) → `o_error`, stays in IDLE.
- **Single beat.** R=C=1, S=E=9 → one beat: bank 0, address 0, `o_last`=1, then `o_done`.
- **Abort, reset and restart.** Assert `i_abort` at beat 10 → IDLE next cycle with no `o_done`. Assert `i_rst` mid-RUN → all outputs 0 next cycle. A restart then begins again at address 0.

Source files
------------

// File: rtl/output_bram_address_generator_pkg.sv
// Shared state type, traversal modes and default sizing for the output BRAM
// address generator and the BRAM wrapper it feeds.
package output_bram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } out_gen_state_t;

  localparam logic MODE_PLANAR = 1'b0;
  localparam logic MODE_PIXEL  = 1'b1;

  localparam int OUTPUT_CHANNEL_WIDTH_DEF = 8;
  localparam int OUTPUT_ROW_WIDTH_DEF     = 6;
  localparam int OUTPUT_COL_WIDTH_DEF     = 6;
  localparam int OUTPUT_BRAM_NUM_DEF      = 4;
  localparam int OUTPUT_BRAM_DEPTH_DEF    = 1152;

endpackage

// File: rtl/output_bram_address_generator_if.sv
// Beat stream from the address generator to the output BRAM write port.
interface output_bram_address_generator_if
  import output_bram_pkg::*;
#(
  parameter int CH_W   = OUTPUT_CHANNEL_WIDTH_DEF,
  parameter int ROW_W  = OUTPUT_ROW_WIDTH_DEF,
  parameter int COL_W  = OUTPUT_COL_WIDTH_DEF,
  parameter int ADDR_W = $clog2(OUTPUT_BRAM_DEPTH_DEF),
  parameter int BANK_W = $clog2(OUTPUT_BRAM_NUM_DEF)
);
  logic              o_valid;
  logic              i_ready;
  logic [BANK_W-1:0] o_bank_sel;
  logic [ADDR_W-1:0] o_output_feature_address;
  logic [CH_W-1:0]   o_output_feature_channel_data_point;
  logic [ROW_W-1:0]  o_output_feature_row_data_point;
  logic [COL_W-1:0]  o_output_feature_col_data_point;
  logic              o_last;

  modport master (
    output o_valid, o_bank_sel, o_output_feature_address,
           o_output_feature_channel_data_point, o_output_feature_row_data_point,
           o_output_feature_col_data_point, o_last,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_bank_sel, o_output_feature_address,
           o_output_feature_channel_data_point, o_output_feature_row_data_point,
           o_output_feature_col_data_point, o_last,
    output i_ready
  );
endinterface

// File: rtl/output_bram_address_generator_config_checker.sv
// Tile legality check and plane size (R*C); evaluated only when a start is sampled.
module output_tile_config_checker
  import output_bram_pkg::*;
#(
  parameter int CH_W   = OUTPUT_CHANNEL_WIDTH_DEF,
  parameter int ROW_W  = OUTPUT_ROW_WIDTH_DEF,
  parameter int COL_W  = OUTPUT_COL_WIDTH_DEF,
  parameter int ADDR_W = $clog2(OUTPUT_BRAM_DEPTH_DEF),
  parameter int BANK_W = $clog2(OUTPUT_BRAM_NUM_DEF),
  parameter int DEPTH  = OUTPUT_BRAM_DEPTH_DEF
) (
  input  logic [ROW_W-1:0]       row_cnt,
  input  logic [COL_W-1:0]       col_cnt,
  input  logic [CH_W-1:0]        start_ch,
  input  logic [CH_W-1:0]        end_ch,
  output logic                   cfg_ok,
  output logic [ROW_W+COL_W-1:0] plane_size
);
  localparam int WIDE = ADDR_W + CH_W + ROW_W + COL_W;
  localparam int PW   = ROW_W + COL_W;

  logic [CH_W-1:0] span;
  logic [WIDE-1:0] groups;
  logic [WIDE-1:0] need;

  // Wide enough that groups*R*C cannot wrap for any input combination.
  assign span       = end_ch - start_ch;
  assign groups     = WIDE'(span >> BANK_W) + WIDE'(1);
  assign need       = groups * WIDE'(row_cnt) * WIDE'(col_cnt);
  assign plane_size = PW'(row_cnt) * PW'(col_cnt);
  assign cfg_ok     = (end_ch >= start_ch) && (row_cnt != '0) && (col_cnt != '0)
                      && (need <= WIDE'(DEPTH));
endmodule

// File: rtl/output_bram_address_generator.sv
// Walks an output tile and issues one BRAM write target per handshake, building
// addresses incrementally (base per channel group + pixel offset).
module output_bram_address_generator
  import output_bram_pkg::*;
#(
  parameter int OUTPUT_CHANNEL_WIDTH      = OUTPUT_CHANNEL_WIDTH_DEF,
  parameter int OUTPUT_ROW_WIDTH          = OUTPUT_ROW_WIDTH_DEF,
  parameter int OUTPUT_COL_WIDTH          = OUTPUT_COL_WIDTH_DEF,
  parameter int OUTPUT_BRAM_NUM           = OUTPUT_BRAM_NUM_DEF,
  parameter int OUTPUT_BRAM_DEPTH         = OUTPUT_BRAM_DEPTH_DEF,
  parameter int OUTPUT_BRAM_ADDRESS_WIDTH = $clog2(OUTPUT_BRAM_DEPTH),
  parameter int BANK_SEL_WIDTH            = $clog2(OUTPUT_BRAM_NUM)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic                            i_mode,
  input  logic [OUTPUT_ROW_WIDTH-1:0]     i_output_feature_row,
  input  logic [OUTPUT_COL_WIDTH-1:0]     i_output_feature_col,
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0] i_output_start_index_channel,
  input  logic [OUTPUT_CHANNEL_WIDTH-1:0] i_output_end_index_channel,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error,
  output_bram_address_generator_if.master beat
);
  localparam int CH_W   = OUTPUT_CHANNEL_WIDTH;
  localparam int ROW_W  = OUTPUT_ROW_WIDTH;
  localparam int COL_W  = OUTPUT_COL_WIDTH;
  localparam int ADDR_W = OUTPUT_BRAM_ADDRESS_WIDTH;
  localparam int BANK_W = BANK_SEL_WIDTH;

  localparam logic [CH_W-1:0]   CH_ONE   = CH_W'(1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [BANK_W-1:0] BANK_ONE = BANK_W'(1);

  // state | meaning
  // IDLE  | waiting for a start; config errors pulse o_error here
  // RUN   | presenting beats, advancing on each handshake
  // DONE  | one-cycle completion pulse, then back to IDLE
  out_gen_state_t state_q, state_d;

  logic                    mode_q, mode_d;
  logic [ROW_W-1:0]        row_cnt_q, row_cnt_d, row_q, row_d, row_nx;
  logic [COL_W-1:0]        col_cnt_q, col_cnt_d, col_q, col_d, col_nx;
  logic [CH_W-1:0]         s_q, s_d, e_q, e_d, ch_q, ch_d;
  logic [BANK_W-1:0]       bank_q, bank_d;
  logic [ADDR_W-1:0]       plane_q, plane_d, base_q, base_d, pix_q, pix_d, pix_nx;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    valid_q, valid_d, last_q, last_d;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                    col_end, row_end, bank_end, step;
  logic                    cfg_ok;
  logic [ROW_W+COL_W-1:0]  plane_size;

  output_tile_config_checker #(
    .CH_W(CH_W), .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W),
    .BANK_W(BANK_W), .DEPTH(OUTPUT_BRAM_DEPTH)
  ) u_cfg_chk (
    .row_cnt   (i_output_feature_row),
    .col_cnt   (i_output_feature_col),
    .start_ch  (i_output_start_index_channel),
    .end_ch    (i_output_end_index_channel),
    .cfg_ok    (cfg_ok),
    .plane_size(plane_size)
  );

  // Pixel (row/col) step shared by both traversal orders.
  always_comb begin
    col_end  = (col_q == col_cnt_q - COL_ONE);
    row_end  = (row_q == row_cnt_q - ROW_ONE);
    bank_end = (bank_q == '1);
    step     = valid_q && beat.i_ready;
    col_nx   = col_end ? '0 : col_q + COL_ONE;
    row_nx   = row_q;
    pix_nx   = pix_q + ADDR_ONE;
    if (col_end) begin
      row_nx = row_end ? '0 : row_q + ROW_ONE;
      if (row_end) pix_nx = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    s_d       = s_q;
    e_d       = e_q;
    plane_d   = plane_q;
    ch_d      = ch_q;
    row_d     = row_q;
    col_d     = col_q;
    bank_d    = bank_q;
    base_d    = base_q;
    pix_d     = pix_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_abort && i_start) begin
          if (cfg_ok) begin
            state_d   = RUN;
            mode_d    = i_mode;
            row_cnt_d = i_output_feature_row;
            col_cnt_d = i_output_feature_col;
            s_d       = i_output_start_index_channel;
            e_d       = i_output_end_index_channel;
            plane_d   = ADDR_W'(plane_size);
            ch_d      = i_output_start_index_channel;
            row_d     = '0;
            col_d     = '0;
            bank_d    = '0;
            base_d    = '0;
            pix_d     = '0;
            addr_d    = '0;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            last_d    = (i_output_start_index_channel == i_output_end_index_channel)
                        && (i_output_feature_row == ROW_ONE)
                        && (i_output_feature_col == COL_ONE);
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (step && last_q) begin
          state_d = DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (step) begin
          if (mode_q == MODE_PLANAR) begin
            col_d = col_nx;
            row_d = row_nx;
            pix_d = pix_nx;
            if (col_end && row_end) begin
              ch_d   = ch_q + CH_ONE;
              bank_d = bank_q + BANK_ONE;
              if (bank_end) base_d = base_q + plane_q;
            end
          end else if (ch_q != e_q) begin
            ch_d   = ch_q + CH_ONE;
            bank_d = bank_q + BANK_ONE;
            if (bank_end) base_d = base_q + plane_q;
          end else begin
            ch_d   = s_q;
            bank_d = '0;
            base_d = '0;
            col_d  = col_nx;
            row_d  = row_nx;
            pix_d  = pix_nx;
          end
          addr_d = base_d + pix_d;
          last_d = (ch_d == e_q) && (row_d == row_cnt_q - ROW_ONE)
                   && (col_d == col_cnt_q - COL_ONE);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      s_q       <= '0;
      e_q       <= '0;
      plane_q   <= '0;
      ch_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      bank_q    <= '0;
      base_q    <= '0;
      pix_q     <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      s_q       <= s_d;
      e_q       <= e_d;
      plane_q   <= plane_d;
      ch_q      <= ch_d;
      row_q     <= row_d;
      col_q     <= col_d;
      bank_q    <= bank_d;
      base_q    <= base_d;
      pix_q     <= pix_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign beat.o_valid                             = valid_q;
  assign beat.o_bank_sel                          = bank_q;
  assign beat.o_output_feature_address            = addr_q;
  assign beat.o_output_feature_channel_data_point = ch_q;
  assign beat.o_output_feature_row_data_point     = row_q;
  assign beat.o_output_feature_col_data_point     = col_q;
  assign beat.o_last                              = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_error = error_q;
endmodule

// File: tb/tb_output_bram_address_generator.sv
// Randomized bench: beat stream checked against a nested-loop tile model.
module tb_output_bram_address_generator;
  import output_bram_pkg::*;

  localparam int CH_W   = 8;
  localparam int ROW_W  = 6;
  localparam int COL_W  = 6;
  localparam int NUM    = 4;
  localparam int DEPTH  = 1152;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BANK_W = $clog2(NUM);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, abort, mode;
  logic [ROW_W-1:0]  rows;
  logic [COL_W-1:0]  cols;
  logic [CH_W-1:0]   s_ch, e_ch;
  logic              busy, done, err;

  output_bram_address_generator_if #(
    .CH_W(CH_W), .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)
  ) beat_if ();

  output_bram_address_generator #(
    .OUTPUT_CHANNEL_WIDTH(CH_W), .OUTPUT_ROW_WIDTH(ROW_W), .OUTPUT_COL_WIDTH(COL_W),
    .OUTPUT_BRAM_NUM(NUM), .OUTPUT_BRAM_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_output_feature_row(rows), .i_output_feature_col(cols),
    .i_output_start_index_channel(s_ch), .i_output_end_index_channel(e_ch),
    .o_busy(busy), .o_done(done), .o_error(err), .beat(beat_if)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int ch; int row; int col; int bank; int addr; bit last;
  } beat_t;
  beat_t exp_q[$];

  function automatic beat_t make_beat(int ch, int row, int col, int r, int c, int s, int e);
    beat_t b;
    int rel = ch - s;
    b.ch = ch; b.row = row; b.col = col;
    b.bank = rel % NUM;
    b.addr = (rel / NUM) * r * c + row * c + col;
    b.last = (ch == e) && (row == r - 1) && (col == c - 1);
    return b;
  endfunction

  function automatic void build_model(logic m, int r, int c, int s, int e);
    exp_q.delete();
    if (m == MODE_PLANAR) begin
      for (int ch = s; ch <= e; ch++)
        for (int row = 0; row < r; row++)
          for (int col = 0; col < c; col++)
            exp_q.push_back(make_beat(ch, row, col, r, c, s, e));
    end else begin
      for (int row = 0; row < r; row++)
        for (int col = 0; col < c; col++)
          for (int ch = s; ch <= e; ch++)
            exp_q.push_back(make_beat(ch, row, col, r, c, s, e));
    end
  endfunction

  // All tasks are entered and left at a negative clock edge.
  task automatic apply_cfg(logic m, int r, int c, int s, int e);
    mode = m; rows = ROW_W'(r); cols = COL_W'(c); s_ch = CH_W'(s); e_ch = CH_W'(e);
  endtask

  task automatic run_tile(input logic m, input int r, input int c, input int s, input int e,
                          input int stall_pct, input bit noise, input string tag);
    int idx = 0;
    int n;
    int budget;
    bit rdy;
    beat_t x;
    build_model(m, r, c, s, e);
    n = exp_q.size();
    apply_cfg(m, r, c, s, e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || beat_if.o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s start_latency busy=%0b valid=%0b required 1/1", tag, busy, beat_if.o_valid);
    end
    budget = n * 20 + 20;
    while (idx < n && budget > 0) begin
      budget--;
      x = exp_q[idx];
      vectors++;
      if (beat_if.o_valid !== 1'b1 || busy !== 1'b1
          || int'(beat_if.o_output_feature_channel_data_point) !== x.ch
          || int'(beat_if.o_output_feature_row_data_point) !== x.row
          || int'(beat_if.o_output_feature_col_data_point) !== x.col
          || int'(beat_if.o_bank_sel) !== x.bank
          || int'(beat_if.o_output_feature_address) !== x.addr
          || beat_if.o_last !== x.last) begin
        miscompares++;
        $display("FAIL %s beat%0d got v=%0b ch=%0d r=%0d c=%0d bank=%0d addr=%0d last=%0b required ch=%0d r=%0d c=%0d bank=%0d addr=%0d last=%0b",
                 tag, idx, beat_if.o_valid, beat_if.o_output_feature_channel_data_point,
                 beat_if.o_output_feature_row_data_point, beat_if.o_output_feature_col_data_point,
                 beat_if.o_bank_sel, beat_if.o_output_feature_address, beat_if.o_last,
                 x.ch, x.row, x.col, x.bank, x.addr, x.last);
        break;
      end
      rdy = ($urandom_range(99) >= stall_pct);
      beat_if.i_ready = rdy;
      start = (noise && !(rdy && idx == n - 1)) ? 1'($urandom_range(1)) : 1'b0;
      if (rdy) idx++;
      @(negedge clk);
    end
    start = 1'b0;
    beat_if.i_ready = 1'b1;
    vectors++;
    if (idx != n) begin
      miscompares++;
      $display("FAIL %s beat_count got=%0d required=%0d", tag, idx, n);
    end
    vectors++;
    if (beat_if.o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_pulse valid=%0b busy=%0b done=%0b required 0/0/1",
               tag, beat_if.o_valid, busy, done);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || beat_if.o_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_width done=%0b valid=%0b err=%0b required 0/0/0",
               tag, done, beat_if.o_valid, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; beat_if.i_ready = 1'b1;
    apply_cfg(MODE_PLANAR, 2, 3, 0, 7);
    repeat (3) @(negedge clk);
    vectors++;
    if ({beat_if.o_valid, beat_if.o_last, busy, done, err} !== 5'b0
        || beat_if.o_output_feature_address !== '0 || beat_if.o_bank_sel !== '0
        || beat_if.o_output_feature_channel_data_point !== '0) begin
      miscompares++;
      $display("FAIL reset_state valid=%0b busy=%0b done=%0b err=%0b addr=%0d required all 0",
               beat_if.o_valid, busy, done, err, beat_if.o_output_feature_address);
    end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_planar();
    run_tile(MODE_PLANAR, 2, 3, 0, 7, 0, 1'b0, "planar");
  endtask

  task automatic test_pixel();
    run_tile(MODE_PIXEL, 2, 3, 0, 7, 0, 1'b0, "pixel");
  endtask

  task automatic test_backpressure();
    run_tile(MODE_PLANAR, 2, 3, 0, 7, 50, 1'b1, "bp_planar");
    run_tile(MODE_PIXEL, 2, 3, 0, 7, 50, 1'b1, "bp_pixel");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int s = $urandom_range(200);
      run_tile(1'($urandom_range(1)), $urandom_range(1, 4), $urandom_range(1, 4),
               s, s + $urandom_range(9), 40, 1'b1, "random");
    end
  endtask

  task automatic check_reject(int r, int c, int s, int e, string tag);
    apply_cfg(MODE_PLANAR, r, c, s, e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (err !== 1'b1 || beat_if.o_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s error_pulse err=%0b valid=%0b busy=%0b required 1/0/0",
               tag, err, beat_if.o_valid, busy);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || beat_if.o_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s error_width err=%0b valid=%0b busy=%0b required 0/0/0",
               tag, err, beat_if.o_valid, busy);
    end
  endtask

  task automatic test_config_reject();
    check_reject(2, 3, 10, 4, "rej_order");
    check_reject(24, 24, 0, 15, "rej_depth");
    check_reject(24, 24, 0, 8, "rej_depth_edge");
    check_reject(0, 3, 0, 3, "rej_zero_row");
    check_reject(2, 0, 0, 3, "rej_zero_col");
    run_tile(MODE_PLANAR, 24, 24, 0, 7, 0, 1'b0, "full_depth");
  endtask

  task automatic test_single();
    run_tile(MODE_PLANAR, 1, 1, 9, 9, 0, 1'b0, "single");
    run_tile(MODE_PIXEL, 1, 1, 9, 9, 30, 1'b0, "single_px");
  endtask

  task automatic test_abort_reset();
    apply_cfg(MODE_PLANAR, 2, 3, 0, 7);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    vectors++;
    if (beat_if.o_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_over_start valid=%0b busy=%0b required 0/0", beat_if.o_valid, busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (int'(beat_if.o_output_feature_address) !== make_beat(1, 1, 1, 2, 3, 0, 7).addr) begin
      miscompares++;
      $display("FAIL abort_beat10 addr=%0d required=%0d", beat_if.o_output_feature_address,
               make_beat(1, 1, 1, 2, 3, 0, 7).addr);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (beat_if.o_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort valid=%0b busy=%0b done=%0b required 0/0/0", beat_if.o_valid, busy, done);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || beat_if.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done done=%0b valid=%0b required 0/0", done, beat_if.o_valid);
    end
    run_tile(MODE_PIXEL, 3, 2, 5, 11, 20, 1'b0, "after_abort");
    apply_cfg(MODE_PIXEL, 3, 3, 0, 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({beat_if.o_valid, beat_if.o_last, busy, done, err} !== 5'b0
        || beat_if.o_output_feature_address !== '0 || beat_if.o_bank_sel !== '0
        || beat_if.o_output_feature_channel_data_point !== '0
        || beat_if.o_output_feature_row_data_point !== '0
        || beat_if.o_output_feature_col_data_point !== '0) begin
      miscompares++;
      $display("FAIL mid_reset valid=%0b busy=%0b addr=%0d bank=%0d ch=%0d required all 0",
               beat_if.o_valid, busy, beat_if.o_output_feature_address, beat_if.o_bank_sel,
               beat_if.o_output_feature_channel_data_point);
    end
    run_tile(MODE_PLANAR, 2, 3, 0, 7, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_planar();
    test_pixel();
    test_backpressure();
    test_random();
    test_config_reject();
    test_single();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
